cf_fft_1024_8_sel_seq: RTL and testbench

Radix-4 input sequencer for the 1024-point, 8-bit FFT datapath. It sits directly upstream of the 4:1 sample selector. It gathers four consecutive enabled input samples into a parallel bank and drives the 2-bit select that walks the selector across that bank. Frame alignment comes from `sync_i`, and all state advances only on enabled cycles.

---
 rtl/cf_fft_1024_8_sel_seq.sv | 90 +++++++++
 tb/tb_cf_fft_1024_8_sel_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cf_fft_1024_8_sel_seq.sv
// Radix-4 input sequencer for the 1024-point FFT datapath.
// Packs four enabled samples into a bank and walks the 4:1 select.
module cf_fft_1024_8_sel_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock_c,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_0_o,
  output logic [WIDTH-1:0] data_1_o,
  output logic [WIDTH-1:0] data_2_o,
  output logic [WIDTH-1:0] data_3_o,
  output logic [1:0]       sel_o,
  output logic             valid_o,
  output logic             sync_o
);

  logic [1:0]       ph;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [WIDTH-1:0] slot2;
  logic             blk_sync;
  logic             done;

  // A block completes on its 4th sample unless a sync restarts it.
  assign done = !sync_i && (ph == 2'd3);

  // Phase counter and partial-block capture.
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      ph       <= 2'd0;
      slot0    <= '0;
      slot1    <= '0;
      slot2    <= '0;
      blk_sync <= 1'b0;
    end else if (enable_i) begin
      unique case (1'b1)
        sync_i: begin
          slot0    <= data_i;
          ph       <= 2'd1;
          blk_sync <= 1'b1;
        end
        done: begin
          ph <= 2'd0;
        end
        default: begin
          unique case (ph)
            2'd0:    slot0 <= data_i;
            2'd1:    slot1 <= data_i;
            default: slot2 <= data_i;
          endcase
          ph <= ph + 2'd1;
          if (ph == 2'd0)
            blk_sync <= 1'b0;
        end
      endcase
    end
  end

  // Bank load, valid/sync flags and selector walk.
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      data_0_o <= '0;
      data_1_o <= '0;
      data_2_o <= '0;
      data_3_o <= '0;
      sel_o    <= 2'd0;
      valid_o  <= 1'b0;
      sync_o   <= 1'b0;
    end else if (enable_i) begin
      if (done) begin
        data_0_o <= slot0;
        data_1_o <= slot1;
        data_2_o <= slot2;
        data_3_o <= data_i;
        sel_o    <= 2'd0;
        valid_o  <= 1'b1;
        sync_o   <= blk_sync;
      end else begin
        sel_o  <= sel_o + 2'd1;
        sync_o <= 1'b0;
        if (sync_i && (ph != 2'd0))
          valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cf_fft_1024_8_sel_seq.sv
// Self-checking bench for cf_fft_1024_8_sel_seq.
// Directed test-plan steps followed by a random stream against a block model.
module tb_cf_fft_1024_8_sel_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sy = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] d0, d1, d2, d3;
  logic [1:0] sel;
  logic       valid;
  logic       so;

  int tests = 0;
  int fails = 0;

  // Reference model: a list of samples in the open block.
  logic [7:0] blk[$];
  logic       m_bsync = 1'b0;
  logic [7:0] m_bank[4] = '{default: 8'h00};
  logic [1:0] m_sel = 2'd0;
  logic       m_valid = 1'b0;
  logic       m_so = 1'b0;

  always #5 clk = ~clk;

  cf_fft_1024_8_sel_seq #(.WIDTH(8)) dut (
    .clock_c (clk),
    .reset_i (rst),
    .enable_i(en),
    .sync_i  (sy),
    .data_i  (din),
    .data_0_o(d0),
    .data_1_o(d1),
    .data_2_o(d2),
    .data_3_o(d3),
    .sel_o   (sel),
    .valid_o (valid),
    .sync_o  (so)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      blk.delete();
      m_bsync = 1'b0;
      m_bank = '{default: 8'h00};
      m_sel = 2'd0;
      m_valid = 1'b0;
      m_so = 1'b0;
    end else if (en) begin
      if (sy) begin
        if (blk.size() != 0) m_valid = 1'b0;
        blk.delete();
        blk.push_back(din);
        m_bsync = 1'b1;
        m_sel = m_sel + 2'd1;
        m_so = 1'b0;
      end else if (blk.size() == 3) begin
        blk.push_back(din);
        for (int i = 0; i < 4; i++) m_bank[i] = blk[i];
        blk.delete();
        m_sel = 2'd0;
        m_valid = 1'b1;
        m_so = m_bsync;
      end else begin
        if (blk.size() == 0) m_bsync = 1'b0;
        blk.push_back(din);
        m_sel = m_sel + 2'd1;
        m_so = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("data_0", 32'(d0), 32'(m_bank[0]));
    check("data_1", 32'(d1), 32'(m_bank[1]));
    check("data_2", 32'(d2), 32'(m_bank[2]));
    check("data_3", 32'(d3), 32'(m_bank[3]));
    check("sel", 32'(sel), 32'(m_sel));
    check("valid", 32'(valid), 32'(m_valid));
    check("sync", 32'(so), 32'(m_so));
  endtask

  task automatic step(input logic r, input logic e, input logic s,
                      input logic [7:0] d);
    rst = r;
    en = e;
    sy = s;
    din = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    #1;
    // reset state
    step(1, 0, 0, 8'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);

    // synced block 0x10..0x13
    step(0, 1, 1, 8'h10);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h12);
    step(0, 1, 0, 8'h13);
    check("p1_d0", 32'(d0), 32'h10);
    check("p1_d3", 32'(d3), 32'h13);
    check("p1_sync", 32'(so), 32'd1);
    check("p1_valid", 32'(valid), 32'd1);

    // continuous stream 0x20..0x27
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h20 + i));
    check("p2_d0", 32'(d0), 32'h24);
    check("p2_d3", 32'(d3), 32'h27);
    check("p2_sync", 32'(so), 32'd0);
    check("p2_sel", 32'(sel), 32'd0);

    // sync on the third sample of a block
    step(0, 1, 0, 8'h40);
    step(0, 1, 0, 8'h41);
    step(0, 1, 1, 8'h42);
    check("p3_drop", 32'(valid), 32'd0);
    step(0, 1, 0, 8'h43);
    step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h45);
    check("p3_d0", 32'(d0), 32'h42);
    check("p3_sync", 32'(so), 32'd1);

    // enable gaps with garbage data
    step(0, 1, 0, 8'h30);
    step(0, 0, 1, 8'hFF);
    step(0, 0, 0, 8'hFF);
    step(0, 1, 0, 8'h31);
    step(0, 1, 0, 8'h32);
    step(0, 1, 0, 8'h33);
    check("p4_d1", 32'(d1), 32'h31);
    check("p4_d3", 32'(d3), 32'h33);

    // reset mid-block
    step(0, 1, 0, 8'h50);
    step(0, 1, 0, 8'h51);
    step(1, 1, 1, 8'h52);
    check("p5_valid", 32'(valid), 32'd0);
    check("p5_d0", 32'(d0), 32'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h60 + i));
    check("p5_d0_load", 32'(d0), 32'h60);

    // sync while a block is on its last sample
    step(0, 1, 0, 8'h70);
    step(0, 1, 0, 8'h71);
    step(0, 1, 0, 8'h72);
    step(0, 1, 1, 8'h73);
    check("p6_valid", 32'(valid), 32'd0);
    check("p6_d0", 32'(d0), 32'h60);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h74 + i));
    check("p6_d0_load", 32'(d0), 32'h73);

    // random stream
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 11) == 0),
           8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
